crc32_rx_check: RTL
===================

CRC32_RX_CHECK -- requirements
Module: crc32_rx_check

Interface
REQ-001 The block SHALL have parameter MIN_LEN, default 64: minimum legal frame length in bytes, FCS included.
REQ-002 The block SHALL have parameter CNT_W, default 32: width of the frame statistics counters.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 data_in  input  8  received byte; data_in[0] is the first bit on the wire.
REQ-006 data_valid  input  1  data_in is accepted on a rising clk edge when this is high.
REQ-007 sof  input  1  the accepted byte is the first byte of a frame; qualified by data_valid.
REQ-008 eof  input  1  the accepted byte is the last FCS byte of a frame; qualified by data_valid.
REQ-009 frame_done  output  1  one-cycle pulse; the status outputs are valid in this cycle.
REQ-010 frame_ok  output  1  with frame_done: FCS matches and length >= MIN_LEN.
REQ-011 crc_err  output  1  with frame_done: FCS mismatch.
REQ-012 runt  output  1  with frame_done: length < MIN_LEN.
REQ-013 frame_abort  output  1  one-cycle pulse when an open frame is abandoned by a new sof.
REQ-014 frame_len  output  16  byte count of the last completed frame, FCS included, saturating at 0xFFFF.
REQ-015 good_cnt, bad_cnt  output  CNT_W each  totals of ok frames and of bad frames (crc_err or runt); wrap modulo 2^CNT_W.

Function
REQ-016 The CRC SHALL use polynomial 0x04C11DB7, be processed 8 bits per accepted byte with data_in[0] first, and be initialised to 0xFFFFFFFF at each sof.
REQ-017 Accepted bytes SHALL pass through a 4-byte delay line; only a byte leaving the delay line SHALL update the CRC, so the last four bytes (the FCS) are excluded.
REQ-018 At eof, FCS byte n (n = 0..3, wire order) SHALL be compared with the expected value whose bit i = NOT crc[31-8n-i].
REQ-019 The FSM SHALL have three states: IDLE, FILL (fewer than 4 bytes held) and RUN.
REQ-020 FSM transitions SHALL be: IDLE->FILL on sof; FILL->RUN on the 4th byte; FILL/RUN->IDLE on eof; any state->FILL on sof.
REQ-021 frame_done and the status bits SHALL assert exactly one cycle after the eof byte is accepted.
REQ-022 frame_len, good_cnt and bad_cnt SHALL update on that same edge.
REQ-023 If length < 4 at eof, the frame SHALL report runt=1 and crc_err=0 with no FCS compare.
REQ-024 If 4 <= length < MIN_LEN, the frame SHALL report runt=1, and crc_err SHALL reflect the FCS compare.
REQ-025 frame_ok SHALL equal NOT(crc_err OR runt).
REQ-026 sof and eof on the same byte SHALL be a 1-byte frame: runt=1, reported next cycle.
REQ-027 sof while in FILL or RUN SHALL pulse frame_abort next cycle, leave the counters unchanged and start a new frame with this byte.
REQ-028 In IDLE, bytes without sof, including eof, SHALL be ignored.
REQ-029 data_valid low SHALL freeze all frame state, for any number of cycles.
REQ-030 The status bits SHALL be 0 whenever frame_done is 0.

Reset
REQ-031 On rst, the FSM SHALL return to IDLE.
REQ-032 On rst, the CRC register SHALL load 0xFFFFFFFF and the delay line SHALL clear.
REQ-033 On rst, all outputs, frame_len and both counters SHALL go to 0.
REQ-034 rst asserted mid-frame SHALL discard the frame with no frame_done and no frame_abort.

Structure
REQ-035 Package crc32_pkg SHALL hold the polynomial, the init value 0xFFFFFFFF and the FSM state enum.
REQ-036 One combinational sub-module, crc32_d8_next, SHALL implement the 32-bit CRC next-state function for an 8-bit input; the FSM, delay line, compare logic and counters SHALL be in crc32_rx_check.

Verification
REQ-037 MIN_LEN=4; frame "123456789" followed by 26 39 F4 CB, continuous valid -> one cycle after eof: frame_ok=1, frame_len=13, good_cnt=1.
REQ-038 The same frame with last byte CA -> crc_err=1, frame_ok=0, bad_cnt=1.
REQ-039 Default MIN_LEN; the same correct 13-byte frame -> runt=1, crc_err=0, bad_cnt+1.
REQ-040 REQ-037 frame with data_valid randomly low for 0-3 cycles between bytes -> identical result.
REQ-041 sof at byte 6 of an open frame, then a full correct frame -> frame_abort pulse, then one frame_ok; counters +1 good only.
REQ-042 rst pulse after byte 5, then a correct frame -> no frame_done for the first frame, the second is ok; sof+eof on a single byte -> runt=1, frame_len=1.

Source files
------------

// File: rtl/crc32_pkg.sv
// Shared constants and FSM state type for the CRC-32 receive checker.
package crc32_pkg;

    // Ethernet CRC-32 generator polynomial (normal form)
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    // Register value at the start of every frame
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    // IDLE: no open frame; FILL: fewer than 4 bytes held; RUN: delay line full
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StRun  = 2'd2
    } state_e;

endpackage

// File: rtl/crc32_d8_next.sv
// CRC-32 next-state function for one byte, bit 0 of the byte entering first.
module crc32_d8_next
    import crc32_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    // Eight unrolled serial LFSR steps, LSB of the byte first
    always_comb begin
        logic [31:0] c;
        logic        fb;
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data_i[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/crc32_rx_check.sv
// Receive-side frame checker: FCS verification, length check and frame statistics.
// The last four bytes of each frame are held back in a delay line so they never
// enter the CRC; at eof they are compared against the inverted, bit-reversed CRC.
module crc32_rx_check
    import crc32_pkg::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic             sof,
    input  logic             eof,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             crc_err,
    output logic             runt,
    output logic             frame_abort,
    output logic [15:0]      frame_len,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    state_e            state_q;
    logic [31:0]       crc_q;
    logic [3:0][7:0]   dly_q;      // [0] newest byte, [3] oldest
    logic [15:0]       len_q;      // bytes of the open frame so far
    logic              done_q, ok_q, crc_err_q, runt_q, abort_q;
    logic [15:0]       frame_len_q;
    logic [CNT_W-1:0]  good_q, bad_q;

    logic [31:0]       crc_step, crc_fin, exp_fcs, rx_fcs;
    logic [15:0]       len_inc, eof_len;
    logic              short_c, runt_c, crc_err_c;

    // CRC advanced by the byte about to leave the delay line
    crc32_d8_next u_crc_next (
        .crc_i  (crc_q),
        .data_i (dly_q[3]),
        .crc_o  (crc_step)
    );

    // FCS compare and length classification for a frame ending on this byte
    always_comb begin
        // In FILL no payload byte has left the delay line yet
        crc_fin = (state_q == StRun) ? crc_step : crc_q;
        for (int i = 0; i < 32; i++) begin
            exp_fcs[i] = ~crc_fin[31-i];
        end
        // Wire-order FCS byte n sits at bits [8n+7:8n]
        rx_fcs    = {data_in, dly_q[0], dly_q[1], dly_q[2]};
        len_inc   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
        eof_len   = sof ? 16'd1 : len_inc;
        short_c   = eof_len < 16'd4;
        runt_c    = short_c || (32'(eof_len) < MIN_LEN);
        crc_err_c = !short_c && (rx_fcs != exp_fcs);
    end

    // Frame FSM, delay line, CRC register, status pulses and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            crc_q       <= CRC_INIT;
            dly_q       <= '0;
            len_q       <= '0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            crc_err_q   <= 1'b0;
            runt_q      <= 1'b0;
            abort_q     <= 1'b0;
            frame_len_q <= '0;
            good_q      <= '0;
            bad_q       <= '0;
        end else begin
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            crc_err_q <= 1'b0;
            runt_q    <= 1'b0;
            abort_q   <= 1'b0;
            if (data_valid && (sof || state_q != StIdle)) begin
                dly_q <= {dly_q[2:0], data_in};
                if (sof) begin
                    abort_q <= (state_q != StIdle);
                    crc_q   <= CRC_INIT;
                    len_q   <= 16'd1;
                    state_q <= eof ? StIdle : StFill;
                end else begin
                    if (state_q == StRun) begin
                        crc_q <= crc_step;
                    end
                    len_q <= len_inc;
                    if (!eof && state_q == StFill && len_q == 16'd3) begin
                        state_q <= StRun;
                    end else if (eof) begin
                        state_q <= StIdle;
                    end
                end
                if (eof) begin
                    done_q      <= 1'b1;
                    ok_q        <= !(runt_c || crc_err_c);
                    crc_err_q   <= crc_err_c;
                    runt_q      <= runt_c;
                    frame_len_q <= eof_len;
                    if (runt_c || crc_err_c) begin
                        bad_q <= bad_q + CNT_W'(1);
                    end else begin
                        good_q <= good_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign frame_done  = done_q;
    assign frame_ok    = ok_q;
    assign crc_err     = crc_err_q;
    assign runt        = runt_q;
    assign frame_abort = abort_q;
    assign frame_len   = frame_len_q;
    assign good_cnt    = good_q;
    assign bad_cnt     = bad_q;

endmodule
